// File: rtl/serializador_saida_if.sv
`default_nettype none
// ============================================================================
// Module      : serializador_saida_if
// Description : Parallel-load / serial-out handshake bundle for the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface serializador_saida_if;
  logic [7:0] q;
  logic       load;
  logic       ready;
  logic       busy;
  logic       tx;
  logic       frame_done;

  modport master (
    output q, load,
    input  ready, busy, tx, frame_done
  );

  modport slave (
    input  q, load,
    output ready, busy, tx, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/serializador_saida.sv
`default_nettype none
// ============================================================================
// Module      : serializador_saida
// Description : UART-style frame serializer (start, 8 data LSB first,
//               optional even parity, stop) fed from the 8-bit registrador.
// Revision    : 1.0 - initial release
// ============================================================================
module serializador_saida #(
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                  clkSimulation,
  input  logic                  rst,
  serializador_saida_if.slave   bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  localparam logic [7:0] c_BAUD_LAST = 8'(BAUD_DIV - 1);

  logic [2:0] r_state;
  logic [7:0] r_shift;
  logic       r_par;
  logic [2:0] r_bitcnt;
  logic [7:0] r_baud;
  logic       r_tx;
  logic       r_frame_done;

  logic [2:0] w_state;
  logic [7:0] w_shift;
  logic       w_par;
  logic [2:0] w_bitcnt;
  logic [7:0] w_baud;
  logic       w_bit_end;
  logic       w_tx;
  logic       w_frame_done;

  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift;
    w_par     = r_par;
    w_bitcnt  = r_bitcnt;
    w_baud    = r_baud + 8'd1;
    w_bit_end = (r_baud == c_BAUD_LAST);

    case (r_state)
      c_IDLE: begin
        w_baud = 8'd0;
        if (bus.load) begin
          w_shift  = bus.q;
          w_par    = ^bus.q;
          w_bitcnt = 3'd0;
          w_state  = c_START;
        end
      end
      c_START: begin
        if (w_bit_end) begin
          w_baud  = 8'd0;
          w_state = c_DATA;
        end
      end
      c_DATA: begin
        if (w_bit_end) begin
          w_baud   = 8'd0;
          w_shift  = {1'b0, r_shift[7:1]};
          w_bitcnt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_state = (PARITY_EN != 0) ? c_PARITY : c_STOP;
          end
        end
      end
      c_PARITY: begin
        if (w_bit_end) begin
          w_baud  = 8'd0;
          w_state = c_STOP;
        end
      end
      c_STOP: begin
        if (w_bit_end) begin
          w_baud  = 8'd0;
          w_state = c_IDLE;
        end
      end
      default: begin
        w_baud  = 8'd0;
        w_state = c_IDLE;
      end
    endcase
  end

  // Line level and done pulse are decoded from the next state so both leave a flop.
  always_comb begin
    case (w_state)
      c_START:  w_tx = 1'b0;
      c_DATA:   w_tx = w_shift[0];
      c_PARITY: w_tx = w_par;
      default:  w_tx = 1'b1;
    endcase
    w_frame_done = (w_state == c_STOP) && (w_baud == c_BAUD_LAST);
  end

  always_ff @(posedge clkSimulation) begin
    if (!rst) begin
      r_state      <= c_IDLE;
      r_shift      <= 8'd0;
      r_par        <= 1'b0;
      r_bitcnt     <= 3'd0;
      r_baud       <= 8'd0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_shift      <= w_shift;
      r_par        <= w_par;
      r_bitcnt     <= w_bitcnt;
      r_baud       <= w_baud;
      r_tx         <= w_tx;
      r_frame_done <= w_frame_done;
    end
  end

  assign bus.ready      = (r_state == c_IDLE);
  assign bus.busy       = (r_state != c_IDLE);
  assign bus.tx         = r_tx;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
